// File: rtl/trajectory_feeder.sv
// trajectory_feeder: buffers host waypoints in a FIFO and issues them one at a
// time to an external judge, advancing on success and stopping on a fail,
// re-plan request or verdict timeout.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   wp_valid/wp_data      host waypoint write (axis k in bits [32k+31:32k])
//   wp_ready              FIFO not full
//   start/abort/clear     run control, sticky-fail clear
//   replan_ack            host acknowledges a re-plan request
//   stepperPosition       waypoint currently presented to the judge
//   judge_req             one-cycle pulse, stepperPosition is new
//   deadline(_valid)      judge verdict: 0 fail, 255 success, else re-plan time
//   busy/done/fail        run status
//   replan_req/replan_time re-plan handshake and latched deadline
//   wp_count              FIFO occupancy
module trajectory_feeder #(
  parameter int unsigned STEPPERS_NUM = 6,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         wp_valid,
  input  logic [32*STEPPERS_NUM-1:0]   wp_data,
  output logic                         wp_ready,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         clear,
  input  logic                         replan_ack,
  output logic [32*STEPPERS_NUM-1:0]   stepperPosition,
  output logic                         judge_req,
  input  logic [7:0]                   deadline,
  input  logic                         deadline_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic                         replan_req,
  output logic [7:0]                   replan_time,
  output logic [$clog2(DEPTH):0]       wp_count
);

  localparam int unsigned DW = 32 * STEPPERS_NUM;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_REPLAN, S_FAIL, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [TW-1:0] timer;

  logic full, wr_en, pop, flush, set_fail, set_replan, ack_replan, issue;

  assign full     = (count == CW'(DEPTH));
  assign wp_count = count;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    flush      = 1'b0;
    set_fail   = 1'b0;
    set_replan = 1'b0;
    ack_replan = 1'b0;
    issue      = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
      flush      = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (start && count != '0 && !fail) next_state = S_ISSUE;
        S_ISSUE: begin
          issue      = 1'b1;
          next_state = S_WAIT;
        end
        S_WAIT: begin
          if (deadline_valid) begin
            if (deadline == 8'd255) begin
              pop = 1'b1;
              // A write in the same cycle is always accepted while popping,
              // so the FIFO drains only when the last entry leaves unreplaced.
              next_state = (count == CW'(1) && !wp_valid) ? S_DONE : S_ISSUE;
            end else if (deadline == 8'd0) begin
              set_fail   = 1'b1;
              next_state = S_FAIL;
            end else begin
              set_replan = 1'b1;
              next_state = S_REPLAN;
            end
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            set_fail   = 1'b1;
            next_state = S_FAIL;
          end
        end
        S_REPLAN: if (replan_ack) begin
          ack_replan = 1'b1;
          flush      = 1'b1;
          next_state = S_IDLE;
        end
        S_FAIL:  next_state = S_IDLE;
        S_DONE:  next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
    // A pop frees a slot in the same cycle, so a full FIFO may still take a write.
    wr_en     = wp_valid && (!full || pop) && !flush;
    count_nxt = flush ? '0 : CW'(count + CW'(wr_en) - CW'(pop));
  end

  // FIFO storage (no reset needed; occupancy is tracked by count)
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wp_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
    end
  end

  // Registered outputs and verdict timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      stepperPosition <= '0;
      judge_req       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      replan_req      <= 1'b0;
      replan_time     <= '0;
      wp_ready        <= 1'b1;
      timer           <= '0;
    end else begin
      judge_req <= issue;
      done      <= (next_state == S_DONE);
      busy      <= (next_state != S_IDLE);
      wp_ready  <= (count_nxt != CW'(DEPTH));
      if (issue) stepperPosition <= mem[rd_ptr];

      if (issue)              timer <= '0;
      else if (state == S_WAIT) timer <= timer + TW'(1);

      if (abort)         fail <= 1'b0;
      else if (set_fail) fail <= 1'b1;
      else if (clear)    fail <= 1'b0;

      if (abort || ack_replan) replan_req <= 1'b0;
      else if (set_replan)     replan_req <= 1'b1;

      if (set_replan) replan_time <= deadline;
    end
  end

endmodule
